axil_write_snoop_multi: RTL and testbench

- Transparent AXI4-Lite pass-through (s0 to m0) that snoops completed write transactions.
- Compares each write against N_WATCH programmable address/value/mask entries.
- Emits a one-cycle hit pulse per matching entry and keeps a saturating per-entry hit counter.
- Sits between the register-map interconnect and a downstream register block. Replaces single-address, single-bit spoof detectors with one generic instance.

---
 rtl/axil_snoop_pkg.sv | 27 ++
 rtl/axil_snoop_match.sv | 41 ++++
 rtl/axil_write_snoop_multi.sv | 220 ++++++++++++++++++++++
 tb/tb_axil_write_snoop_multi.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/axil_snoop_pkg.sv
// Shared types, limits and helpers for the AXI4-Lite write snooper.
package axil_snoop_pkg;

  localparam int unsigned N_WATCH_MIN = 1;
  localparam int unsigned N_WATCH_MAX = 16;
  localparam int unsigned TIMEOUT_MIN = 1;
  localparam int unsigned TIMEOUT_MAX = 255;
  localparam int unsigned MAX_STRB_W  = 128;
  localparam int unsigned MAX_DATA_W  = MAX_STRB_W * 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2
  } pair_state_t;

  // Expand byte strobes to a per-bit mask; callers truncate to their data width.
  function automatic logic [MAX_DATA_W-1:0] strb_to_bits(input logic [MAX_STRB_W-1:0] strb);
    logic [MAX_DATA_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < int'(MAX_STRB_W); i++) begin
      bits[i*8 +: 8] = {8{strb[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/axil_snoop_match.sv
// One watch entry: address/value/mask comparator, hit pulse and saturating hit counter.
module axil_snoop_match
  import axil_snoop_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CNT_W      = 16,
  parameter logic [ADDR_W-1:0] WATCH_ADDR = '0,
  parameter logic [DATA_W-1:0] WATCH_MASK = DATA_W'(1),
  parameter logic [DATA_W-1:0] WATCH_VAL  = DATA_W'(1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              eval,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] strb_bits,
  output logic              match_c,
  output logic              hit,
  output logic [CNT_W-1:0]  cnt
);

  // A masked byte that was not written can never satisfy the entry.
  assign match_c = eval
                && (addr == WATCH_ADDR)
                && (((data ^ WATCH_VAL) & WATCH_MASK & strb_bits) == '0)
                && ((WATCH_MASK & ~strb_bits) == '0);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hit <= 1'b0;
      cnt <= '0;
    end else begin
      hit <= match_c;
      if (hit && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/axil_write_snoop_multi.sv
// Zero-latency AXI4-Lite pass-through that pairs completed AW/W handshakes
// and flags writes matching any of N_WATCH programmable address/value/mask entries.
module axil_write_snoop_multi
  import axil_snoop_pkg::*;
#(
  parameter int unsigned               ADDR_W     = 16,
  parameter int unsigned               DATA_W     = 32,
  parameter int unsigned               N_WATCH    = 4,
  parameter logic [N_WATCH*ADDR_W-1:0] WATCH_ADDR = '0,
  parameter logic [N_WATCH*DATA_W-1:0] WATCH_MASK = {N_WATCH{DATA_W'(1)}},
  parameter logic [N_WATCH*DATA_W-1:0] WATCH_VAL  = {N_WATCH{DATA_W'(1)}},
  parameter int unsigned               TIMEOUT    = 7,
  parameter int unsigned               CNT_W      = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_W-1:0]         s0_awaddr,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_W-1:0]         s0_wdata,
  input  logic [DATA_W/8-1:0]       s0_wstrb,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ADDR_W-1:0]         s0_araddr,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [DATA_W-1:0]         s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,
  output logic [ADDR_W-1:0]         m0_awaddr,
  output logic                      m0_awvalid,
  input  logic                      m0_awready,
  output logic [DATA_W-1:0]         m0_wdata,
  output logic [DATA_W/8-1:0]       m0_wstrb,
  output logic                      m0_wvalid,
  input  logic                      m0_wready,
  input  logic [1:0]                m0_bresp,
  input  logic                      m0_bvalid,
  output logic                      m0_bready,
  output logic [ADDR_W-1:0]         m0_araddr,
  output logic                      m0_arvalid,
  input  logic                      m0_arready,
  input  logic [DATA_W-1:0]         m0_rdata,
  input  logic [1:0]                m0_rresp,
  input  logic                      m0_rvalid,
  output logic                      m0_rready,
  output logic [N_WATCH-1:0]        hit,
  output logic                      hit_any,
  output logic [N_WATCH*CNT_W-1:0]  hit_cnt,
  output logic                      timeout_pulse,
  output logic                      overflow
);

  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned WD_W        = $clog2(TIMEOUT_MAX + 1);
  localparam int unsigned TIMEOUT_EFF = (TIMEOUT < TIMEOUT_MIN) ? TIMEOUT_MIN :
                                        (TIMEOUT > TIMEOUT_MAX) ? TIMEOUT_MAX : TIMEOUT;

  if ((N_WATCH < N_WATCH_MIN) || (N_WATCH > N_WATCH_MAX) || ((DATA_W % 8) != 0)) begin : g_bad_param
    $error("axil_write_snoop_multi: N_WATCH or DATA_W out of range");
  end

  // Bus wiring: untouched by reset and never stalled.
  assign m0_awaddr  = s0_awaddr;
  assign m0_awvalid = s0_awvalid;
  assign s0_awready = m0_awready;
  assign m0_wdata   = s0_wdata;
  assign m0_wstrb   = s0_wstrb;
  assign m0_wvalid  = s0_wvalid;
  assign s0_wready  = m0_wready;
  assign s0_bresp   = m0_bresp;
  assign s0_bvalid  = m0_bvalid;
  assign m0_bready  = s0_bready;
  assign m0_araddr  = s0_araddr;
  assign m0_arvalid = s0_arvalid;
  assign s0_arready = m0_arready;
  assign s0_rdata   = m0_rdata;
  assign s0_rresp   = m0_rresp;
  assign s0_rvalid  = m0_rvalid;
  assign m0_rready  = s0_rready;

  logic              r1_aw, r1_w;
  logic [ADDR_W-1:0] r1_awaddr;
  logic [DATA_W-1:0] r1_wdata;
  logic [STRB_W-1:0] r1_wstrb;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r1_aw <= 1'b0;
      r1_w  <= 1'b0;
    end else begin
      r1_aw <= s0_awvalid & s0_awready;
      r1_w  <= s0_wvalid & s0_wready;
    end
  end

  always_ff @(posedge aclk) begin
    r1_awaddr <= s0_awaddr;
    r1_wdata  <= s0_wdata;
    r1_wstrb  <= s0_wstrb;
  end

  pair_state_t       state;
  logic [WD_W-1:0]   wd;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [STRB_W-1:0] hold_strb;
  logic              pair_valid;
  logic [ADDR_W-1:0] pair_addr;
  logic [DATA_W-1:0] pair_data;
  logic [STRB_W-1:0] pair_strb;

  // Pairing FSM: the first half waits for its partner until the watchdog runs out;
  // a repeated half on the same channel is flagged and dropped.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      wd            <= '0;
      timeout_pulse <= 1'b0;
      overflow      <= 1'b0;
      pair_valid    <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      pair_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (r1_aw && r1_w) begin
            pair_valid <= 1'b1;
            pair_addr  <= r1_awaddr;
            pair_data  <= r1_wdata;
            pair_strb  <= r1_wstrb;
          end else if (r1_aw) begin
            hold_addr <= r1_awaddr;
            wd        <= WD_W'(TIMEOUT_EFF);
            state     <= HAVE_AW;
          end else if (r1_w) begin
            hold_data <= r1_wdata;
            hold_strb <= r1_wstrb;
            wd        <= WD_W'(TIMEOUT_EFF);
            state     <= HAVE_W;
          end
        end
        HAVE_AW: begin
          if (r1_aw) overflow <= 1'b1;
          if (r1_w) begin
            pair_valid <= 1'b1;
            pair_addr  <= hold_addr;
            pair_data  <= r1_wdata;
            pair_strb  <= r1_wstrb;
            wd         <= '0;
            state      <= IDLE;
          end else if (wd <= WD_W'(1)) begin
            timeout_pulse <= 1'b1;
            wd            <= '0;
            state         <= IDLE;
          end else begin
            wd <= wd - WD_W'(1);
          end
        end
        HAVE_W: begin
          if (r1_w) overflow <= 1'b1;
          if (r1_aw) begin
            pair_valid <= 1'b1;
            pair_addr  <= r1_awaddr;
            pair_data  <= hold_data;
            pair_strb  <= hold_strb;
            wd         <= '0;
            state      <= IDLE;
          end else if (wd <= WD_W'(1)) begin
            timeout_pulse <= 1'b1;
            wd            <= '0;
            state         <= IDLE;
          end else begin
            wd <= wd - WD_W'(1);
          end
        end
        default: begin
          wd    <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  logic [DATA_W-1:0]  strb_bits_c;
  logic [N_WATCH-1:0] match_c;

  assign strb_bits_c = DATA_W'(strb_to_bits(MAX_STRB_W'(pair_strb)));

  for (genvar i = 0; i < N_WATCH; i++) begin : g_watch
    axil_snoop_match #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .CNT_W      (CNT_W),
      .WATCH_ADDR (WATCH_ADDR[i*ADDR_W +: ADDR_W]),
      .WATCH_MASK (WATCH_MASK[i*DATA_W +: DATA_W]),
      .WATCH_VAL  (WATCH_VAL[i*DATA_W +: DATA_W])
    ) u_match (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .eval      (pair_valid),
      .addr      (pair_addr),
      .data      (pair_data),
      .strb_bits (strb_bits_c),
      .match_c   (match_c[i]),
      .hit       (hit[i]),
      .cnt       (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) hit_any <= 1'b0;
    else          hit_any <= |match_c;
  end

endmodule

// File: tb/tb_axil_write_snoop_multi.sv
// Directed bench for axil_write_snoop_multi: pairing, timeout, strobe rule,
// multi-match with counter saturation, overflow and mid-transaction reset.
module tb_axil_write_snoop_multi;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_WATCH = 4;
  localparam int unsigned CNT_W   = 4;

  logic aclk = 1'b0;
  logic aresetn;

  logic [ADDR_W-1:0]        s0_awaddr, s0_araddr, m0_awaddr, m0_araddr;
  logic                     s0_awvalid, s0_awready, s0_wvalid, s0_wready;
  logic [DATA_W-1:0]        s0_wdata, s0_rdata, m0_wdata, m0_rdata;
  logic [DATA_W/8-1:0]      s0_wstrb, m0_wstrb;
  logic [1:0]               s0_bresp, s0_rresp, m0_bresp, m0_rresp;
  logic                     s0_bvalid, s0_bready, s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic                     m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic                     m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [N_WATCH-1:0]       hit;
  logic                     hit_any, timeout_pulse, overflow;
  logic [N_WATCH*CNT_W-1:0] hit_cnt;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  always #5 aclk = ~aclk;

  axil_write_snoop_multi #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .N_WATCH    (N_WATCH),
    .WATCH_ADDR ({16'h0040, 16'h0040, 16'h0020, 16'h6010}),
    .WATCH_MASK ({32'h0000_0000, 32'h0000_0000, 32'h0000_FF00, 32'h0000_0001}),
    .WATCH_VAL  ({32'h0000_0000, 32'h0000_0000, 32'h0000_3400, 32'h0000_0001}),
    .TIMEOUT    (7),
    .CNT_W      (CNT_W)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .s0_awaddr (s0_awaddr), .s0_awvalid (s0_awvalid), .s0_awready (s0_awready),
    .s0_wdata (s0_wdata), .s0_wstrb (s0_wstrb), .s0_wvalid (s0_wvalid), .s0_wready (s0_wready),
    .s0_bresp (s0_bresp), .s0_bvalid (s0_bvalid), .s0_bready (s0_bready),
    .s0_araddr (s0_araddr), .s0_arvalid (s0_arvalid), .s0_arready (s0_arready),
    .s0_rdata (s0_rdata), .s0_rresp (s0_rresp), .s0_rvalid (s0_rvalid), .s0_rready (s0_rready),
    .m0_awaddr (m0_awaddr), .m0_awvalid (m0_awvalid), .m0_awready (m0_awready),
    .m0_wdata (m0_wdata), .m0_wstrb (m0_wstrb), .m0_wvalid (m0_wvalid), .m0_wready (m0_wready),
    .m0_bresp (m0_bresp), .m0_bvalid (m0_bvalid), .m0_bready (m0_bready),
    .m0_araddr (m0_araddr), .m0_arvalid (m0_arvalid), .m0_arready (m0_arready),
    .m0_rdata (m0_rdata), .m0_rresp (m0_rresp), .m0_rvalid (m0_rvalid), .m0_rready (m0_rready),
    .hit (hit), .hit_any (hit_any), .hit_cnt (hit_cnt),
    .timeout_pulse (timeout_pulse), .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_bus();
    s0_awvalid = 1'b0;
    s0_wvalid  = 1'b0;
  endtask

  task automatic drv_aw(input logic [ADDR_W-1:0] a);
    s0_awaddr  = a;
    s0_awvalid = 1'b1;
  endtask

  task automatic drv_w(input logic [DATA_W-1:0] d, input logic [3:0] s);
    s0_wdata  = d;
    s0_wstrb  = s;
    s0_wvalid = 1'b1;
  endtask

  // Called in the cycle the completing handshake is driven; hit must appear 3 cycles later, once.
  task automatic watch_hit(input string tag, input logic [N_WATCH-1:0] exp);
    tick(); idle_bus();
    chk({tag, "_c1"}, 64'(hit), 64'(0));
    tick();
    chk({tag, "_c2"}, 64'(hit), 64'(0));
    tick();
    chk({tag, "_c3"}, 64'(hit), 64'(exp));
    chk({tag, "_any"}, 64'(hit_any), 64'(|exp));
    tick();
    chk({tag, "_c4"}, 64'(hit), 64'(0));
  endtask

  initial begin
    aresetn = 1'b0;
    idle_bus();
    s0_awaddr = '0; s0_wdata = '0; s0_wstrb = '0; s0_bready = 1'b1;
    s0_araddr = '0; s0_arvalid = 1'b0; s0_rready = 1'b1;
    m0_awready = 1'b1; m0_wready = 1'b1; m0_bresp = 2'b00; m0_bvalid = 1'b0;
    m0_arready = 1'b1; m0_rdata = '0; m0_rresp = 2'b00; m0_rvalid = 1'b0;
    tick(); tick();

    // Pass-through while held in reset
    drv_aw(16'h1234); drv_w(32'hCAFE_0001, 4'hF);
    m0_rdata = 32'hA5A5_5A5A; m0_bvalid = 1'b1; m0_bresp = 2'b10;
    #1;
    chk("pt_awaddr", 64'(m0_awaddr), 64'(16'h1234));
    chk("pt_awvalid", 64'(m0_awvalid), 64'(1));
    chk("pt_wdata", 64'(m0_wdata), 64'(32'hCAFE_0001));
    chk("pt_rdata", 64'(s0_rdata), 64'(32'hA5A5_5A5A));
    chk("pt_bvalid", 64'(s0_bvalid), 64'(1));
    chk("pt_bresp", 64'(s0_bresp), 64'(2'b10));
    tick(); idle_bus(); m0_bvalid = 1'b0; m0_bresp = 2'b00;
    tick(); aresetn = 1'b1;
    tick();
    chk("rst_hit", 64'(hit), 64'(0));
    chk("rst_hit_any", 64'(hit_any), 64'(0));
    chk("rst_cnt", 64'(hit_cnt), 64'(0));
    chk("rst_timeout", 64'(timeout_pulse), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));

    // AW and W in the same cycle
    drv_aw(16'h6010); drv_w(32'h1, 4'hF);
    watch_hit("simul", 4'b0001);
    chk("simul_cnt", 64'(hit_cnt), 64'(16'h0001));

    // W four cycles ahead of AW
    drv_w(32'h1, 4'hF);
    tick(); idle_bus(); tick(); tick(); tick();
    drv_aw(16'h6010);
    watch_hit("wfirst", 4'b0001);
    chk("wfirst_cnt", 64'(hit_cnt), 64'(16'h0002));

    // Nine-cycle gap: W half expires, the late AW then expires on its own
    drv_w(32'h1, 4'hF);
    for (int k = 1; k <= 19; k++) begin
      tick(); idle_bus();
      if (k == 9) drv_aw(16'h6010);
      chk("gap9_timeout", 64'(timeout_pulse), 64'((k == 9) || (k == 18)));
      chk("gap9_hit", 64'(hit), 64'(0));
    end
    chk("gap9_cnt", 64'(hit_cnt), 64'(16'h0002));

    // Masked byte not strobed, then strobed
    drv_aw(16'h0020); drv_w(32'h3400, 4'h1);
    watch_hit("strb_lo", 4'b0000);
    drv_aw(16'h0020); drv_w(32'h3400, 4'h2);
    watch_hit("strb_hi", 4'b0010);

    // Twenty back-to-back writes hitting entries 2 and 3 together
    for (int k = 0; k < 24; k++) begin
      if (k < 20) begin
        drv_aw(16'h0040); drv_w(32'(k * 17), 4'hF);
      end else begin
        idle_bus();
      end
      chk("multi_hit", 64'(hit), 64'(((k >= 3) && (k <= 22)) ? 4'b1100 : 4'b0000));
      tick();
    end
    chk("multi_cnt_sat", 64'(hit_cnt), 64'(16'hFF12));

    // Second AW while AW pending: flagged, W pairs with the first address
    chk("ovf_pre", 64'(overflow), 64'(0));
    drv_aw(16'h6010);
    tick(); drv_aw(16'h7000);
    tick(); idle_bus(); drv_w(32'h1, 4'hF);
    watch_hit("ovf_pair", 4'b0001);
    chk("ovf_set", 64'(overflow), 64'(1));
    tick(); tick();
    chk("ovf_sticky", 64'(overflow), 64'(1));
    chk("ovf_cnt", 64'(hit_cnt), 64'(16'hFF13));

    // Reset while an AW is pending; bus keeps flowing during reset
    drv_aw(16'h6010);
    tick(); idle_bus(); tick();
    aresetn = 1'b0; drv_w(32'h2, 4'hF); m0_bvalid = 1'b1;
    #1;
    chk("rstmid_wvalid", 64'(m0_wvalid), 64'(1));
    chk("rstmid_wdata", 64'(m0_wdata), 64'(32'h2));
    chk("rstmid_wready", 64'(s0_wready), 64'(1));
    chk("rstmid_bvalid", 64'(s0_bvalid), 64'(1));
    tick(); aresetn = 1'b1; idle_bus(); m0_bvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("rstmid_hit", 64'(hit), 64'(0));
      chk("rstmid_timeout", 64'(timeout_pulse), 64'(0));
    end
    chk("rstmid_overflow", 64'(overflow), 64'(0));
    chk("rstmid_cnt", 64'(hit_cnt), 64'(0));

    // Snooping resumes normally after reset
    drv_aw(16'h6010); drv_w(32'hFFFF_FFFF, 4'hF);
    watch_hit("post_rst", 4'b0001);
    chk("post_rst_cnt", 64'(hit_cnt), 64'(16'h0001));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
